// File: rtl/hex_digit_scanner.sv
// hex_digit_scanner
// Time-multiplexes a NUM_DIGITS-digit hex value onto one shared 7-segment
// display. Each slot opens with a blanking gap to suppress ghosting. New
// values enter through a valid/ready port into a one-entry pending register.
// They are committed to the display only at the frame boundary, so a frame
// never mixes old and new digits.
module hex_digit_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int SLOT_CYCLES  = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    LoadValid,
  input  logic [4*NUM_DIGITS-1:0] LoadData,
  output logic                    LoadReady,
  input  logic [NUM_DIGITS-1:0]   BlankMask,
  output logic [NUM_DIGITS-1:0]   DigitEn,
  output logic [3:0]              Nibble
);

  localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } state_t;

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic [IDX_W-1:0]        idx_reg, idx_next;
  logic [4*NUM_DIGITS-1:0] display_reg, display_next;
  logic [4*NUM_DIGITS-1:0] pending_reg, pending_next;
  logic                    pending_full_reg, pending_full_next;
  logic [NUM_DIGITS-1:0]   digit_en_reg, digit_en_next;
  logic [3:0]              nibble_reg, nibble_next;

  logic                    slot_end;
  logic                    frame_wrap;
  logic                    load_accept;
  logic [3:0]              digit_val [NUM_DIGITS];

  // The port is ready exactly when the one-entry pending register is empty.
  assign LoadReady = ~pending_full_reg;
  assign DigitEn   = digit_en_reg;
  assign Nibble    = nibble_reg;

  // State, slot timing, value registers and the registered display outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg        <= ST_BLANK;
      cnt_reg          <= '0;
      idx_reg          <= '0;
      display_reg      <= '0;
      pending_reg      <= '0;
      pending_full_reg <= 1'b0;
      digit_en_reg     <= '0;
      nibble_reg       <= '0;
    end else begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      idx_reg          <= idx_next;
      display_reg      <= display_next;
      pending_reg      <= pending_next;
      pending_full_reg <= pending_full_next;
      digit_en_reg     <= digit_en_next;
      nibble_reg       <= nibble_next;
    end
  end

  // Next-state logic: slot counter, BLANK/ON phase, digit index and the
  // pending-to-display transfer at the frame boundary.
  always_comb begin
    state_next        = state_reg;
    cnt_next          = cnt_reg + CNT_W'(1);
    idx_next          = idx_reg;
    display_next      = display_reg;
    pending_next      = pending_reg;
    pending_full_next = pending_full_reg;

    slot_end    = (cnt_reg == CNT_W'(SLOT_CYCLES - 1));
    frame_wrap  = slot_end && (idx_reg == IDX_W'(NUM_DIGITS - 1));
    load_accept = LoadValid && !pending_full_reg;

    case (state_reg)
      ST_BLANK: begin
        // Last blank cycle: the digit lights up from the next cycle on.
        if (cnt_reg == CNT_W'(BLANK_CYCLES - 1)) begin
          state_next = ST_ON;
        end
      end
      ST_ON: begin
        if (slot_end) begin
          state_next = ST_BLANK;
        end
      end
      default: state_next = ST_BLANK;
    endcase

    if (slot_end) begin
      cnt_next = '0;
      idx_next = frame_wrap ? '0 : idx_reg + IDX_W'(1);
    end

    // The frame boundary commits a waiting value. A load and a commit never
    // coincide because the port is not ready while the pending register is full.
    if (frame_wrap && pending_full_reg) begin
      display_next      = pending_reg;
      pending_full_next = 1'b0;
    end

    if (load_accept) begin
      pending_next      = LoadData;
      pending_full_next = 1'b1;
    end
  end

  // The outputs are computed from the next-cycle view, so the registered
  // DigitEn and Nibble line up with the slot counter. Nibble takes the freshly
  // committed display value on the first blank cycle of a frame.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign digit_val[gi]     = display_next[4*gi +: 4];
      assign digit_en_next[gi] = (state_next == ST_ON) &&
                                 (idx_next == IDX_W'(gi)) &&
                                 !BlankMask[gi];
    end
  endgenerate

  assign nibble_next = digit_val[idx_next];

endmodule

// File: tb/tb_hex_digit_scanner.sv
// Self-checking bench for hex_digit_scanner (4 digits, 8-cycle slots,
// 2 blank cycles). The reference model follows the absolute cycle count
// since reset. The slot and position are derived arithmetically from that
// count. The pending/display values follow the handshake rules.
module tb_hex_digit_scanner;

  localparam int ND    = 4;
  localparam int SC    = 8;
  localparam int BC    = 2;
  localparam int FRAME = ND * SC;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        LoadValid = 1'b0;
  logic [15:0] LoadData = '0;
  logic        LoadReady;
  logic [3:0]  BlankMask = '0;
  logic [3:0]  DigitEn;
  logic [3:0]  Nibble;

  hex_digit_scanner #(
    .NUM_DIGITS  (ND),
    .SLOT_CYCLES (SC),
    .BLANK_CYCLES(BC)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .LoadValid(LoadValid),
    .LoadData (LoadData),
    .LoadReady(LoadReady),
    .BlankMask(BlankMask),
    .DigitEn  (DigitEn),
    .Nibble   (Nibble)
  );

  always #5 Clk = ~Clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state.
  int          m_t = 0;
  logic [15:0] m_disp = '0;
  logic [15:0] m_pend = '0;
  bit          m_full = 1'b0;
  int          slot, pos;
  logic [3:0]  exp_en;
  logic [3:0]  exp_nib;
  logic        exp_ready;

  // Advance one clock edge and update the model from the inputs at that edge.
  task automatic step();
    bit acc, xfer;
    @(posedge Clk);
    if (Reset) begin
      m_t    = 0;
      m_disp = '0;
      m_full = 1'b0;
    end else begin
      acc  = LoadValid && !m_full;
      xfer = ((m_t % FRAME) == FRAME - 1) && m_full;
      if (xfer) begin
        m_disp = m_pend;
        m_full = 1'b0;
      end
      if (acc) begin
        m_pend = LoadData;
        m_full = 1'b1;
      end
      m_t++;
    end
    slot      = (m_t / SC) % ND;
    pos       = m_t % SC;
    exp_en    = (pos >= BC) ? (4'(1 << slot) & ~BlankMask) : 4'b0000;
    exp_nib   = m_disp[slot*4 +: 4];
    exp_ready = !m_full;
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    step();
    step();
    n_total++;
    if ({DigitEn, Nibble, LoadReady} !== {4'b0000, 4'h0, 1'b1})
      $display("FAIL reset_state got en=%b nib=%h rdy=%b want en=0000 nib=0 rdy=1",
               DigitEn, Nibble, LoadReady);
    else n_pass++;
    Reset = 1'b0;
    for (int c = 0; c < SC; c++) begin
      if (c > 0) step();
      n_total++;
      if ({DigitEn, Nibble, LoadReady} !== {(c >= BC) ? 4'b0001 : 4'b0000, 4'h0, 1'b1})
        $display("FAIL reset_release c=%0d got en=%b nib=%h rdy=%b", c, DigitEn, Nibble, LoadReady);
      else n_pass++;
      n_total++;
      if ({DigitEn, Nibble, LoadReady} !== {exp_en, exp_nib, exp_ready})
        $display("FAIL reset_model t=%0d got en=%b nib=%h rdy=%b want en=%b nib=%h rdy=%b",
                 m_t, DigitEn, Nibble, LoadReady, exp_en, exp_nib, exp_ready);
      else n_pass++;
    end
  endtask

  task automatic test_scan_order();
    int hi_cnt [ND];
    logic [3:0] seq [ND];
    LoadValid = 1'b1;
    LoadData  = 16'h1234;
    step();
    LoadValid = 1'b0;
    for (int i = 0; i < 2 * FRAME && (m_t % FRAME) != 0; i++) step();
    n_total++;
    if ((m_t % FRAME) != 0) $display("FAIL scan_wait timeout t=%0d", m_t);
    else n_pass++;
    for (int d = 0; d < ND; d++) hi_cnt[d] = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) step();
      n_total++;
      if ({DigitEn, Nibble, LoadReady} !== {exp_en, exp_nib, exp_ready})
        $display("FAIL scan_model t=%0d got en=%b nib=%h rdy=%b want en=%b nib=%h rdy=%b",
                 m_t, DigitEn, Nibble, LoadReady, exp_en, exp_nib, exp_ready);
      else n_pass++;
      for (int d = 0; d < ND; d++) if (DigitEn == 4'(1 << d)) hi_cnt[d]++;
      if (pos == 0) seq[slot] = Nibble;
    end
    for (int d = 0; d < ND; d++) begin
      n_total++;
      if (hi_cnt[d] !== SC - BC)
        $display("FAIL scan_on_time digit=%0d got %0d want %0d", d, hi_cnt[d], SC - BC);
      else n_pass++;
      n_total++;
      if (seq[d] !== 4'(4 - d))
        $display("FAIL scan_nibble digit=%0d got %h want %h", d, seq[d], 4'(4 - d));
      else n_pass++;
    end
  endtask

  task automatic test_load_mid_frame();
    for (int i = 0; i < 2 * FRAME && !(slot == 1 && pos == 3); i++) step();
    n_total++;
    if (!(slot == 1 && pos == 3)) $display("FAIL midload_wait timeout t=%0d", m_t);
    else n_pass++;
    LoadValid = 1'b1;
    LoadData  = 16'hBEEF;
    step();
    LoadValid = 1'b0;
    n_total++;
    if (LoadReady !== 1'b0) $display("FAIL midload_ready got %b want 0", LoadReady);
    else n_pass++;
    for (int i = 0; i < 2 * FRAME && (m_t % FRAME) != 0; i++) begin
      step();
      n_total++;
      if ({DigitEn, Nibble, LoadReady} !== {exp_en, exp_nib, exp_ready})
        $display("FAIL midload_model t=%0d got en=%b nib=%h rdy=%b want en=%b nib=%h rdy=%b",
                 m_t, DigitEn, Nibble, LoadReady, exp_en, exp_nib, exp_ready);
      else n_pass++;
      if ((m_t % FRAME) == FRAME - 1) begin
        n_total++;
        if (Nibble !== 4'h1) $display("FAIL midload_old_digit3 got %h want 1", Nibble);
        else n_pass++;
      end
    end
    n_total++;
    if ({Nibble, LoadReady} !== {4'hF, 1'b1})
      $display("FAIL midload_commit got nib=%h rdy=%b want nib=f rdy=1", Nibble, LoadReady);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int  t_disp_a = -1, t_disp_5 = -1, t_acc_5 = -1;
    bit  got_a = 1'b0, prev_full;
    LoadValid = 1'b1;
    LoadData  = 16'hAAAA;
    for (int i = 0; i < 4 * FRAME && t_disp_5 < 0; i++) begin
      prev_full = m_full;
      step();
      n_total++;
      if ({DigitEn, Nibble, LoadReady} !== {exp_en, exp_nib, exp_ready})
        $display("FAIL b2b_model t=%0d got en=%b nib=%h rdy=%b want en=%b nib=%h rdy=%b",
                 m_t, DigitEn, Nibble, LoadReady, exp_en, exp_nib, exp_ready);
      else n_pass++;
      if (!prev_full && m_full) begin
        if (!got_a && m_pend == 16'hAAAA) begin
          got_a    = 1'b1;
          LoadData = 16'h5555;
        end else if (m_pend == 16'h5555) begin
          t_acc_5   = m_t;
          LoadValid = 1'b0;
        end
      end
      if (m_disp == 16'hAAAA && t_disp_a < 0) begin
        t_disp_a = m_t;
        n_total++;
        if (Nibble !== 4'hA) $display("FAIL b2b_show_a got %h want a", Nibble);
        else n_pass++;
      end
      if (m_disp == 16'h5555 && t_disp_5 < 0) begin
        t_disp_5 = m_t;
        n_total++;
        if (Nibble !== 4'h5) $display("FAIL b2b_show_5 got %h want 5", Nibble);
        else n_pass++;
      end
    end
    LoadValid = 1'b0;
    n_total++;
    if (!(t_disp_a >= 0 && t_acc_5 > t_disp_a))
      $display("FAIL b2b_accept_order got acc5=%0d dispA=%0d want acc5>dispA", t_acc_5, t_disp_a);
    else n_pass++;
    n_total++;
    if (t_disp_5 - t_disp_a !== FRAME)
      $display("FAIL b2b_frame_gap got %0d want %0d", t_disp_5 - t_disp_a, FRAME);
    else n_pass++;
  endtask

  task automatic test_blank_mask();
    int seen_on;
    BlankMask = 4'b0100;
    step();
    seen_on = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      n_total++;
      if ({DigitEn, Nibble, LoadReady} !== {exp_en, exp_nib, exp_ready})
        $display("FAIL mask_model t=%0d got en=%b nib=%h rdy=%b want en=%b nib=%h rdy=%b",
                 m_t, DigitEn, Nibble, LoadReady, exp_en, exp_nib, exp_ready);
      else n_pass++;
      if (DigitEn != 4'b0000) seen_on++;
    end
    n_total++;
    if (seen_on !== 2 * (ND - 1) * (SC - BC))
      $display("FAIL mask_on_cycles got %0d want %0d", seen_on, 2 * (ND - 1) * (SC - BC));
    else n_pass++;
    BlankMask = 4'b0000;
  endtask

  task automatic test_mid_reset();
    LoadValid = 1'b1;
    LoadData  = 16'h9C3E;
    step();
    LoadValid = 1'b0;
    for (int i = 0; i < 2 * FRAME && !(slot == 2 && pos == 4); i++) step();
    n_total++;
    if ({DigitEn, LoadReady} !== {4'b0100, 1'b0})
      $display("FAIL midrst_pre got en=%b rdy=%b want en=0100 rdy=0", DigitEn, LoadReady);
    else n_pass++;
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    n_total++;
    if ({DigitEn, Nibble, LoadReady} !== {4'b0000, 4'h0, 1'b1})
      $display("FAIL midrst_state got en=%b nib=%h rdy=%b want en=0000 nib=0 rdy=1",
               DigitEn, Nibble, LoadReady);
    else n_pass++;
    for (int i = 0; i < FRAME + 4; i++) begin
      step();
      n_total++;
      if ({DigitEn, Nibble, LoadReady} !== {exp_en, 4'h0, 1'b1})
        $display("FAIL midrst_after t=%0d got en=%b nib=%h rdy=%b want en=%b nib=0 rdy=1",
                 m_t, DigitEn, Nibble, LoadReady, exp_en);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 1500; i++) begin
      LoadValid = ($urandom_range(0, 3) == 0);
      LoadData  = 16'($urandom);
      if ($urandom_range(0, 49) == 0) BlankMask = 4'($urandom);
      Reset = ($urandom_range(0, 299) == 0);
      step();
      n_total++;
      if ({DigitEn, Nibble, LoadReady} !== {exp_en, exp_nib, exp_ready}) begin
        if (errs < 10)
          $display("FAIL random_model t=%0d got en=%b nib=%h rdy=%b want en=%b nib=%h rdy=%b",
                   m_t, DigitEn, Nibble, LoadReady, exp_en, exp_nib, exp_ready);
        errs++;
      end else n_pass++;
    end
    Reset = 1'b0;
    LoadValid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan_order();
    test_load_mid_frame();
    test_back_to_back();
    test_blank_mask();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
